pipe_stage_fifo: RTL and testbench
==================================

Name: pipe_stage_fifo

Overview:
- Parametrised successor to the fixed single-entry valid/allow stage registers between IF/ID/EX/MEM/WB.
- Implements a DEPTH-entry, DATA_W-wide elastic stage buffer using the same valid/allow handshake, plus a synchronous flush for branch/exception squash.
- Drops in wherever a stage boundary needs decoupling, e.g. the IF->ID boundary to absorb fetch latency, or the EX->MEM boundary to tolerate data-SRAM stalls.

Parameters:
- DATA_W, 64, width of the stage bus (IF->ID uses 64, ID->EX uses 117).
- DEPTH, 2, number of entries; must be a power of two and >= 1.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count output (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  asynchronous active-low reset.
- flush  input  1  synchronous squash of all entries (branch taken / exception).
- in_valid  input  1  upstream stage holds a valid entry (valid_N).
- in_allow  output  1  this buffer can accept an entry this cycle (allow_N+1 to upstream).
- in_data  input  DATA_W  upstream stage bus.
- out_valid  output  1  head entry is valid (valid to downstream).
- out_allow  input  1  downstream accepts this cycle (allow from downstream).
- out_data  output  DATA_W  head entry data.
- count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Storage: circular buffer with wr_ptr and rd_ptr of $clog2(DEPTH) bits (0 bits when DEPTH=1, i.e. a single register) and an occupancy counter.
- Pointers wrap from DEPTH-1 to 0.
- push = in_valid & in_allow & ~flush.
- pop = out_valid & out_allow & ~flush.
- in_allow = (count != DEPTH); purely combinational from state (see Optional Feature).
- out_valid = (count != 0); out_data = mem[rd_ptr]. Both are registered-state driven, never combinational from in_*.
- Latency: an entry pushed in cycle T is visible on out_* in cycle T+1. There is no same-cycle bypass from in_data to out_data.
- Push only: write mem[wr_ptr], then wr_ptr++ and count++.
- Pop only: rd_ptr++ and count--.
- Push and pop in the same cycle: both pointers advance and count is unchanged. Legal whenever 0 < count < DEPTH.
- Full (count == DEPTH): in_allow = 0 and in_valid is ignored. A pop still proceeds.
- Empty (count == 0): out_valid = 0 and out_allow is ignored. out_data is don't-care but must not be X after reset (mem is reset to 0).
- Flush:
  - Next cycle, count = 0, wr_ptr = rd_ptr = 0 and out_valid = 0.
  - Any push or pop presented in the flush cycle is discarded.
  - Memory contents are not cleared.
  - in_allow during the flush cycle is the normal value; the upstream must also squash itself.
- Reset (resetn = 0, asynchronous):
  - count = 0, pointers = 0, mem = 0.
  - Outputs: out_valid = 0, in_allow = 1, count = 0, out_data = 0.
  - Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.
  - Deassertion is synchronised externally.
- Ordering: strict FIFO; no entry is duplicated or lost except by flush or reset.
- Illegal: DEPTH not a power of two. Elaboration fails via a generate-time check.

Optional Feature:
- Macro: PIPE_STAGE_FIFO_PASS_EN.
- Defined: in_allow = (count != DEPTH) | out_allow, so a push is accepted while full provided a pop happens in the same cycle (count stays DEPTH). With DEPTH=1 this exactly reproduces the classic stage-register rule allow_in = ~valid | allow_out.
- Note: when defined, in_allow is combinationally dependent on out_allow; the integrator must ensure no combinational loop through the allow chain.
- Not defined: in_allow = (count != DEPTH) only. in_allow is then a register-derived signal, which breaks the allow timing path at the cost of one bubble when full.

Test Plan:
- Reset check: hold resetn = 0 mid-stream with count = 2 -> immediately out_valid = 0, count = 0, in_allow = 1, out_data = 0; after release, the first push of 0xA5 appears on out_data one cycle later.
- Fill and drain, DEPTH = 4, out_allow = 0: push 0x11, 0x22, 0x33, 0x44 -> count = 4, in_allow = 0, and a fifth push of 0x55 is ignored. Then out_allow = 1 -> out_data reads 0x11, 0x22, 0x33, 0x44 on consecutive cycles, followed by out_valid = 0.
- Simultaneous push/pop across wrap, DEPTH = 4: run 10 cycles with in_valid = out_allow = 1 and data 0..9 -> count holds steady at 1, the output sequence is 0..9 in order, and the pointers wrap twice without loss.
- Flush: count = 3 with a push and a pop both requested in the flush cycle -> next cycle count = 0 and out_valid = 0; a subsequent push of 0x77 emerges as the first output.
- Full with pass, DEPTH = 1:
  - PIPE_STAGE_FIFO_PASS_EN defined, continuous stream 1..5 with out_allow = 1 -> in_allow stays 1 and the output is 1..5 at one per cycle.
  - Macro undefined -> a one-cycle bubble (in_allow = 0) appears whenever the buffer is full.
- Backpressure toggling, DEPTH = 2: out_allow alternates 1,0 while in_valid = 1 with data 0x100 onward -> no loss or duplication, count stays within 0..2, and in_allow = 0 exactly in the cycles where count = 2.

Source files
------------

// File: rtl/pipe_stage_fifo_if.sv
// Stage-boundary handshake bundle for pipe_stage_fifo.
// Upstream side: in_valid/in_data out, in_allow back.
// Downstream side: out_valid/out_data out, out_allow back.
// flush squashes the whole buffer, and count reports its occupancy.
interface pipe_stage_fifo_if #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              flush;
  logic              in_valid;
  logic              in_allow;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_allow;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  count;

  // Pipeline control / neighbouring stages
  modport master (
    output flush, in_valid, in_data, out_allow,
    input  in_allow, out_valid, out_data, count
  );

  // The buffer itself
  modport slave (
    input  flush, in_valid, in_data, out_allow,
    output in_allow, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_stage_fifo.sv
// pipe_stage_fifo: DEPTH-entry elastic stage buffer with valid/allow handshake
// and synchronous flush. The buffer is a circular store with an occupancy
// counter. Data is visible on the output one cycle after it is pushed.
// Optional macro PIPE_STAGE_FIFO_PASS_EN: while the buffer is full, accept a
// push when a pop happens in the same cycle. This makes in_allow depend on
// out_allow combinationally.
module pipe_stage_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  pipe_stage_fifo_if.slave  bus
);
  // A one-entry buffer still gets a 1-bit pointer, held at 0.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("pipe_stage_fifo: DEPTH must be a power of two and >= 1");
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              full, empty, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (DEPTH == 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);

`ifdef PIPE_STAGE_FIFO_PASS_EN
  assign bus.in_allow = ~full | bus.out_allow;
`else
  assign bus.in_allow = ~full;
`endif

  // flush wins over any handshake that happens in the same cycle.
  assign push = bus.in_valid & bus.in_allow & ~bus.flush;
  assign pop  = ~empty & bus.out_allow & ~bus.flush;

  assign bus.out_valid = ~empty;
  assign bus.out_data  = mem[rd_ptr];
  assign bus.count     = cnt;

  // Pointer and occupancy bookkeeping; flush rewinds to empty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      cnt <= cnt + CNT_W'(1);
      else if (pop && !push) cnt <= cnt - CNT_W'(1);
    end
  end

  // Entry storage. Reset clears it so out_data is never X.
  // A flush leaves the contents in place.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end
endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Bench for pipe_stage_fifo. Three instances (DEPTH 4, 1 and 2) share one
// stimulus stream. Each instance is compared against a queue model of a
// bounded FIFO.
module tb_pipe_stage_fifo;
  localparam int DW = 16;
`ifdef PIPE_STAGE_FIFO_PASS_EN
  localparam bit PASS = 1'b1;
`else
  localparam bit PASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic          s_valid, s_allow_o, s_flush;
  logic [DW-1:0] s_data;

  pipe_stage_fifo_if #(.DATA_W(DW), .DEPTH(4)) if4 ();
  pipe_stage_fifo_if #(.DATA_W(DW), .DEPTH(1)) if1 ();
  pipe_stage_fifo_if #(.DATA_W(DW), .DEPTH(2)) if2 ();

  assign if4.in_valid = s_valid; assign if4.in_data = s_data;
  assign if4.out_allow = s_allow_o; assign if4.flush = s_flush;
  assign if1.in_valid = s_valid; assign if1.in_data = s_data;
  assign if1.out_allow = s_allow_o; assign if1.flush = s_flush;
  assign if2.in_valid = s_valid; assign if2.in_data = s_data;
  assign if2.out_allow = s_allow_o; assign if2.flush = s_flush;

  pipe_stage_fifo #(.DATA_W(DW), .DEPTH(4)) u4 (.clk(clk), .resetn(resetn), .bus(if4));
  pipe_stage_fifo #(.DATA_W(DW), .DEPTH(1)) u1 (.clk(clk), .resetn(resetn), .bus(if1));
  pipe_stage_fifo #(.DATA_W(DW), .DEPTH(2)) u2 (.clk(clk), .resetn(resetn), .bus(if2));

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q4[$], q1[$], q2[$];

  task automatic chk(input string dut, input string what,
                     input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", dut, what, obs, exp);
    end
  endtask

  // Compare one instance against its model before the clock edge.
`define CHECK_DUT(IFC, Q, D, TAG) \
  begin \
    chk(TAG, "in_allow", 64'(IFC.in_allow), \
        64'((Q.size() != D) || (PASS && s_allow_o))); \
    chk(TAG, "out_valid", 64'(IFC.out_valid), 64'(Q.size() != 0)); \
    chk(TAG, "count", 64'(IFC.count), 64'(Q.size())); \
    if (Q.size() != 0) chk(TAG, "out_data", 64'(IFC.out_data), 64'(Q[0])); \
  end

  // Apply the bounded-FIFO rules to the model for this cycle.
`define MODEL(Q, D) \
  begin \
    bit alw, vld; \
    alw = (Q.size() != D) || (PASS && s_allow_o); \
    vld = (Q.size() != 0); \
    if (s_flush) Q.delete(); \
    else begin \
      if (vld && s_allow_o) Q.delete(0); \
      if (s_valid && alw) Q.push_back(s_data); \
    end \
  end

  // One clock cycle. It starts and ends 1 time unit after a rising edge.
  task automatic step(input logic v, input logic [DW-1:0] d,
                      input logic a, input logic f);
    s_valid = v; s_data = d; s_allow_o = a; s_flush = f;
    #1;
    `CHECK_DUT(if4, q4, 4, "d4")
    `CHECK_DUT(if1, q1, 1, "d1")
    `CHECK_DUT(if2, q2, 2, "d2")
    `MODEL(q4, 4)
    `MODEL(q1, 1)
    `MODEL(q2, 2)
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("d4", "rst_valid", 64'(if4.out_valid), 64'(0));
    chk("d4", "rst_count", 64'(if4.count), 64'(0));
    chk("d4", "rst_allow", 64'(if4.in_allow), 64'(1));
    chk("d4", "rst_data", 64'(if4.out_data), 64'(0));
    chk("d1", "rst_valid", 64'(if1.out_valid), 64'(0));
    chk("d1", "rst_data", 64'(if1.out_data), 64'(0));
    chk("d2", "rst_count", 64'(if2.count), 64'(0));
    chk("d2", "rst_data", 64'(if2.out_data), 64'(0));
  endtask

  initial begin
    resetn = 1'b1;
    s_valid = 1'b0; s_data = '0; s_allow_o = 1'b0; s_flush = 1'b0;
    #2 resetn = 1'b0;
    #1 chk_reset_outputs();
    @(posedge clk); @(posedge clk);
    #3 resetn = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset while the buffer holds two entries.
    step(1, 16'h0001, 0, 0);
    step(1, 16'h0002, 0, 0);
    chk("d4", "pre_rst_count", 64'(if4.count), 64'(2));
    s_valid = 1'b0;
    resetn = 1'b0;
    #1 chk_reset_outputs();
    q4.delete(); q1.delete(); q2.delete();
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    step(1, 16'h00A5, 0, 0);
    chk("d4", "a5_out", 64'(if4.out_data), 64'(16'h00A5));
    step(0, 16'h0, 1, 0);
    step(0, 16'h0, 1, 0);

    // Fill with backpressure, try a fifth push, then drain.
    step(1, 16'h11, 0, 0);
    step(1, 16'h22, 0, 0);
    step(1, 16'h33, 0, 0);
    step(1, 16'h44, 0, 0);
    chk("d4", "full_count", 64'(if4.count), 64'(4));
    chk("d4", "full_allow", 64'(if4.in_allow), 64'(0));
    step(1, 16'h55, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 16'h0, 1, 0);

    // Simultaneous push/pop: the DEPTH=4 pointers wrap twice.
    for (int i = 0; i < 10; i++) step(1, DW'(i), 1, 0);
    chk("d4", "stream_count", 64'(if4.count), 64'(1));
    for (int i = 0; i < 3; i++) step(0, 16'h0, 1, 0);

    // Flush with a push and a pop requested in the same cycle.
    step(1, 16'h61, 0, 0);
    step(1, 16'h62, 0, 0);
    step(1, 16'h63, 0, 0);
    step(1, 16'h64, 1, 1);
    chk("d4", "flush_count", 64'(if4.count), 64'(0));
    chk("d4", "flush_valid", 64'(if4.out_valid), 64'(0));
    step(1, 16'h77, 0, 0);
    chk("d4", "post_flush_out", 64'(if4.out_data), 64'(16'h77));
    for (int i = 0; i < 2; i++) step(0, 16'h0, 1, 0);

    // Continuous stream 1..5 with the downstream always accepting.
    for (int i = 1; i <= 5; i++) step(1, DW'(i), 1, 0);
    for (int i = 0; i < 4; i++) step(0, 16'h0, 1, 0);

    // Alternating backpressure.
    for (int i = 0; i < 12; i++) step(1, DW'(16'h100 + i), (i % 2) == 0, 0);
    for (int i = 0; i < 6; i++) step(0, 16'h0, 1, 0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 1) == 1,
           $urandom_range(0, 24) == 0);
    for (int i = 0; i < 6; i++) step(0, 16'h0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
